// File: rtl/c499_codeword_feeder.sv
// rtl/c499_codeword_feeder.sv - Registered c499 codeword source with check-bit generation, bit-flip injection and output FIFO.
module c499_codeword_feeder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             inj_en,
    input  logic [5:0]       inj_pos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [7:0]       out_check,
    output logic             out_en,
    output logic [CNT_W-1:0] word_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [39:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, show_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;
    logic [7:0]    chk;
    logic [39:0]   flip_mask, codeword;

    // Check bits chosen so the c499 syndrome of {data, check} is zero.
    always_comb begin
        chk[0] = ^in_data[23:16] ^ in_data[0] ^ in_data[4] ^ in_data[8]  ^ in_data[12];
        chk[1] = ^in_data[31:24] ^ in_data[1] ^ in_data[5] ^ in_data[9]  ^ in_data[13];
        chk[2] = ^in_data[19:16] ^ ^in_data[27:24] ^ in_data[2] ^ in_data[6] ^ in_data[10] ^ in_data[14];
        chk[3] = ^in_data[23:20] ^ ^in_data[31:28] ^ in_data[3] ^ in_data[7] ^ in_data[11] ^ in_data[15];
        chk[4] = ^in_data[7:0]   ^ in_data[16] ^ in_data[20] ^ in_data[24] ^ in_data[28];
        chk[5] = ^in_data[15:8]  ^ in_data[17] ^ in_data[21] ^ in_data[25] ^ in_data[29];
        chk[6] = ^in_data[3:0]   ^ ^in_data[11:8]  ^ in_data[18] ^ in_data[22] ^ in_data[26] ^ in_data[30];
        chk[7] = ^in_data[7:4]   ^ ^in_data[15:12] ^ in_data[19] ^ in_data[23] ^ in_data[27] ^ in_data[31];
    end

    always_comb begin
        flip_mask = '0;
        if (inj_en && (inj_pos < 6'd40))
            flip_mask = 40'd1 << inj_pos;
        codeword = {chk, in_data} ^ flip_mask;
    end

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign in_ready = !full || out_ready;
    assign push     = in_valid && in_ready;
    assign pop      = !empty && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            word_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= codeword;
                wr_ptr      <= wr_ptr + 1'b1;
                word_cnt    <= word_cnt + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // When empty, the slot behind rd_ptr still holds the last popped codeword.
    assign show_ptr  = empty ? (rd_ptr - 1'b1) : rd_ptr;
    assign out_valid = !empty;
    assign out_en    = !empty;
    assign out_data  = mem[show_ptr][31:0];
    assign out_check = mem[show_ptr][39:32];
endmodule
